inst_sram_like_slave: RTL
=========================

// Module: inst_sram_like_slave
// PURPOSE
//  Responder side of the SRAM-like bus driven by the fetch stage (inst_req/inst_addr_ok/inst_data_ok).
//  Accepts address phases, performs the access on a synchronous single-port RAM, returns data phases in order.
//  Sits between fetch (or data-side master) and the on-chip instruction RAM; replaces the behavioural test RAM.
//  Programmable response latency and outstanding depth exercise the master's handshake handling.
// PARAMETERS
//  RAM_AW  14  word-address width of backing RAM (RAM holds 2^RAM_AW 32-bit words)
//  LAT     2   extra response cycles beyond RAM read latency (0..7); data_ok fires 1+LAT cycles after accept
//  MAX_OS  2   max outstanding (accepted, not yet data_ok) requests; 1..8
// PORTS
//  clk        in   1       clock, rising edge
//  resetn     in   1       asynchronous active-low reset
//  req        in   1       master request valid (address phase)
//  wr         in   1       1 = write, 0 = read
//  size       in   2       0 byte, 1 half, 2 word; 3 treated as word
//  addr       in   32      byte address; bits [RAM_AW+1:2] index RAM, [1:0] select lanes
//  wdata      in   32      write data, lane-aligned as in memory
//  addr_ok    out  1       address phase accepted this cycle when req&addr_ok
//  rdata      out  32      read data, valid only in data_ok cycle
//  data_ok    out  1       one-cycle pulse per accepted request, in acceptance order
//  stall      in   1       test hook: forces addr_ok=0 while high
//  ram_en     out  1       RAM port enable
//  ram_wen    out  4       RAM byte write enables
//  ram_addr   out  RAM_AW  RAM word address
//  ram_wdata  out  32      RAM write data
//  ram_rdata  in   32      RAM read data, valid the cycle after ram_en with ram_wen=0
// BEHAVIOUR
//  Reset (async, resetn=0): addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_wen=0, os_cnt=0, delay line cleared.
//  addr_ok = resetn & !stall & (os_cnt < MAX_OS), combinational; independent of req (master may sample early).
//  Accept = req & addr_ok. Same cycle: ram_en=1, ram_addr=addr[RAM_AW+1:2]; for writes ram_wen per strobe, else 0.
//  Strobe: size0 -> 4'b0001<<addr[1:0]; size1 -> addr[1]?4'b1100:4'b0011 (addr[0] ignored); size2/3 -> 4'b1111.
//  No accept -> ram_en=0, ram_wen=0; ram_addr/ram_wdata don't-care.
//  Cycle after accept: capture {wr, ram_rdata (0 for writes)} into entry 0 of a LAT-deep delay line.
//  Entry exits after LAT further cycles: data_ok=1, rdata=captured data; LAT=0 -> data_ok in cycle accept+1.
//  No data-phase back-pressure: master must take data_ok when it fires.
//  os_cnt: +1 on accept, -1 on data_ok, unchanged when both in same cycle; never exceeds MAX_OS.
//  Back-to-back accepts at full rate allowed while os_cnt<MAX_OS; responses keep one-per-cycle spacing of accepts.
//  os_cnt==MAX_OS with data_ok same cycle: addr_ok stays 0 this cycle (no bypass); re-opens next cycle.
//  Read-after-write same word, back-to-back: read sees new data (RAM write completes at accept edge).
//  stall only gates addr_ok; in-flight responses continue to drain.
//  resetn low mid-operation: all in-flight responses dropped, no data_ok after release; RAM contents kept.
//  Address bits above RAM_AW+1 ignored (aliases; kseg1 0xbfc00000 maps to word 0).
// STRUCTURE
//  Shared package: SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, strobe function, STARTADDR constant.
//  Sub-module resp_delay_line (params W, LAT): shift register of {valid, payload}, async clear;
//  top holds os_cnt, accept logic, strobe generation, RAM port drive.
// TESTING
//  Reset then read 0xbfc00000 with RAM[0]=0x3c1dbfc0, LAT=2 -> addr_ok cycle 0, data_ok cycle 3, rdata=0x3c1dbfc0.
//  MAX_OS=2, req held high, stall=0 -> accepts cycles 0,1; addr_ok low cycle 2; data_ok cycles 3,4 in order.
//  Byte write 0xAA to addr 0x...0002 over RAM word 0x11223344 -> ram_wen=4'b0100; readback 0x11AA3344.
//  Half write 0xBEEF at addr[1]=1 then immediate read same word -> readback upper half 0xBEEF, data_ok order kept.
//  stall high 5 cycles with 1 in-flight -> addr_ok=0 throughout, pending data_ok still fires on time.
//  resetn pulsed low between accept and data_ok -> no data_ok after release, os_cnt=0, addr_ok=1 next cycle.

Source files
------------

// File: rtl/inst_sram_like_slave_pkg.sv
// Shared definitions for the SRAM-like instruction slave.
// Size encodings, boot address and byte-strobe helper.
package inst_sram_like_slave_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] STARTADDR = 32'hbfc0_0000;

  // size 3 falls through to a full-word strobe
  function automatic logic [3:0] strobe(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] s;
    s = 4'b1111;
    case (size)
      SIZE_BYTE: s = 4'b0001 << lo;
      SIZE_HALF: s = lo[1] ? 4'b1100 : 4'b0011;
      default:   s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/inst_sram_like_slave_if.sv
// SRAM-like request/response bus between fetch and memory.
// Address phase: req/addr_ok; data phase: data_ok/rdata.
interface inst_sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, rdata, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, rdata, data_ok
  );
endinterface

// File: rtl/inst_sram_like_slave_resp_delay_line.sv
// Fixed-latency shift register of {valid, payload}.
// LAT=0 degenerates to a wire.
module resp_delay_line #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (LAT == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_line
      logic [LAT-1:0] vld;
      logic [W-1:0]   dat [LAT];

      // shift entries toward the output, clear all on reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= '0;
          for (int i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
          vld[0] <= in_valid;
          dat[0] <= in_data;
          for (int i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
          end
        end
      end

      assign out_valid = vld[LAT-1];
      assign out_data  = dat[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/inst_sram_like_slave.sv
// SRAM-like bus responder in front of a sync single-port RAM.
// In-order responses with programmable latency and depth.
module inst_sram_like_slave
  import inst_sram_like_slave_pkg::*;
#(
  parameter int RAM_AW = 14,
  parameter int LAT    = 2,
  parameter int MAX_OS = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  inst_sram_like_slave_if.slave bus,
  input  logic                  stall,
  output logic                  ram_en,
  output logic [3:0]            ram_wen,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  logic [3:0]  os_cnt;
  logic        accept;
  logic        acc_q;
  logic        wr_q;
  logic [31:0] cap;
  logic        dl_valid;
  logic [31:0] dl_data;

  // upper address bits alias onto the RAM
  wire unused_ok = &{1'b0, bus.addr[31:RAM_AW+2]};

  assign bus.addr_ok = resetn & ~stall
                     & (os_cnt < 4'(MAX_OS));
  assign accept      = bus.req & bus.addr_ok;

  assign ram_en    = accept;
  assign ram_wen   = (accept & bus.wr)
                   ? strobe(bus.size, bus.addr[1:0])
                   : 4'b0000;
  assign ram_addr  = bus.addr[RAM_AW+1:2];
  assign ram_wdata = bus.wdata;

  // remember which cycle has RAM read data to capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      acc_q <= accept;
      wr_q  <= accept & bus.wr;
    end
  end

  assign cap = wr_q ? 32'h0 : ram_rdata;

  resp_delay_line #(
    .W   (32),
    .LAT (LAT)
  ) u_dl (
    .clk       (clk),
    .rst_n     (resetn),
    .in_valid  (acc_q),
    .in_data   (cap),
    .out_valid (dl_valid),
    .out_data  (dl_data)
  );

  assign bus.data_ok = dl_valid;
  assign bus.rdata   = dl_data;

  // outstanding count: accepts in, responses out
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      os_cnt <= 4'd0;
    end else if (accept && !dl_valid) begin
      os_cnt <= os_cnt + 4'd1;
    end else if (!accept && dl_valid) begin
      os_cnt <= os_cnt - 4'd1;
    end
  end

endmodule
